up_counter: RTL and testbench
=============================

# up_counter

Programmable up counter, the counting-up counterpart to the team's preloadable down counter. It counts from a loaded start value toward a latched limit and can double its value in one cycle, saturating at the limit. It flags arrival at the limit, wrap-around and overflow for a sequencer or timer controller.

## Interface
- WIDTH, 8, counter and limit width in bits (>= 2)
- clk  input  1  rising-edge clock
- rst  input  1  reset; one clock; reset is synchronous and active-high
- load  input  1  load preload_count and limit_in this cycle
- preload_count  input  WIDTH  start value captured on load
- limit_in  input  WIDTH  limit captured on load
- multiply_by_2  input  1  double count_out this cycle
- enable  input  1  increment enable
- wrap_en  input  1  1: wrap to 0 past limit; 0: hold at limit
- clear_overflow  input  1  clear sticky overflow
- count_out  output  WIDTH  current count (registered)
- at_limit  output  1  combinational, count_out == limit register
- tc  output  1  one-cycle pulse on at_limit rising
- wrap  output  1  one-cycle pulse, count wrapped to 0
- overflow  output  1  sticky; a load or doubling was clamped

## Operation
- Internal limit register limit_q; changes only on rst or load.
- Count-update priority per edge: rst > load > multiply_by_2 > enable.
- rst: count_out=0, limit_q=all ones, overflow=0, tc=0, wrap=0.
- load: limit_q<=limit_in. If preload_count <= limit_in, count_out<=preload_count; else count_out<=limit_in and overflow<=1. Comparison uses limit_in, not old limit_q.
- multiply_by_2 (no load): if count_out <= (limit_q>>1), count_out<=count_out<<1; else count_out<=limit_q and overflow<=1. No WIDTH+1 intermediate needed; 2c > L iff c > floor(L/2).
- enable (no load/double): if count_out != limit_q, count_out<=count_out+1. At limit: wrap_en=1 -> count_out<=0 and wrap pulses; wrap_en=0 -> hold, no flags.
- No action selected: hold.
- count_out > limit_q cannot occur; every path clamps.
- overflow: set by clamp events; cleared by clear_overflow; set wins when both occur in the same cycle. Only rst or clear_overflow clears it.
- tc: high in exactly those cycles where at_limit=1 and at_limit was 0 in the previous cycle. Applies whatever caused the change (increment, load, double, limit change on load). Implement tc as a register from next-state values, not as glitchy combinational logic.
- limit_q=0: at_limit=1 after any load. With wrap_en=1 and enable, count stays 0 and wrap pulses every enabled cycle; tc fires once.

## Timing
- count_out, overflow, tc, wrap update on the rising clk edge; tc and wrap are registered.
- Latency: one edge from load, multiply_by_2 or enable to new count_out. tc and wrap are valid in the same cycle as the count_out value that causes them.
- at_limit is combinational from registers only and has no input-to-output path.
- Reset mid-count overrides all inputs that edge; first action is possible on the edge after rst deasserts.
- Back-to-back loads are allowed every cycle; each load is independent.

## Test plan
- Reset, then enable=1 with limit FF, 255 cycles: count_out 0→FF; tc=1 only in the cycle count_out=FF; at_limit=1 from then on; with wrap_en=0, count holds FF.
- load preload=3, limit=5, wrap_en=1, enable=1: count_out 3,4,5,0,1. tc pulses with 5; wrap pulses with 0; overflow stays 0.
- load preload=20, limit=10: count_out=10, overflow=1, at_limit=1, tc=1 for one cycle. clear_overflow then drops overflow to 0 next cycle.
- limit=9: count 4 + multiply_by_2 -> 8, no overflow. Count 5 + multiply_by_2 -> 9, overflow=1. limit FF, count 80 + multiply_by_2 -> FF, overflow=1.
- Same-cycle load=1, multiply_by_2=1, enable=1 with preload 2: count_out=2 (load wins). clear_overflow plus a clamping double in one cycle: overflow=1.
- Assert rst mid-count at 7 with enable held: next cycle count_out=0, all flags 0, limit_q=FF; counting resumes on the following edge.

Source files
------------

// File: rtl/up_counter.sv
// Programmable up counter with preload, limit, doubling and saturation.
// Flags limit arrival (tc), wrap-around and sticky overflow.
module up_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] preload_count,
    input  logic [WIDTH-1:0] limit_in,
    input  logic             multiply_by_2,
    input  logic             enable,
    input  logic             wrap_en,
    input  logic             clear_overflow,
    output logic [WIDTH-1:0] count_out,
    output logic             at_limit,
    output logic             tc,
    output logic             wrap,
    output logic             overflow
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             ovf_q, ovf_d;
    logic             tc_q, tc_d;
    logic             wrap_q, wrap_d;
    logic             ovf_set;

    always_comb begin
        count_d = count_q;
        limit_d = limit_q;
        ovf_set = 1'b0;
        wrap_d  = 1'b0;
        if (load) begin
            limit_d = limit_in;
            if (preload_count <= limit_in) begin
                count_d = preload_count;
            end else begin
                count_d = limit_in;
                ovf_set = 1'b1;
            end
        end else if (multiply_by_2) begin
            // 2c > L exactly when c > floor(L/2)
            if (count_q <= (limit_q >> 1)) begin
                count_d = count_q << 1;
            end else begin
                count_d = limit_q;
                ovf_set = 1'b1;
            end
        end else if (enable) begin
            if (count_q != limit_q) begin
                count_d = count_q + 1'b1;
            end else if (wrap_en) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end
        end
        ovf_d = ovf_set | (ovf_q & ~clear_overflow);
        tc_d  = (count_d == limit_d) && (count_q != limit_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            limit_q <= '1;
            ovf_q   <= 1'b0;
            tc_q    <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            limit_q <= limit_d;
            ovf_q   <= ovf_d;
            tc_q    <= tc_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_out = count_q;
    assign at_limit  = (count_q == limit_q);
    assign tc        = tc_q;
    assign wrap      = wrap_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_up_counter.sv
// Directed self-checking bench for up_counter.
module tb_up_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] preload_count;
    logic [7:0] limit_in;
    logic       multiply_by_2;
    logic       enable;
    logic       wrap_en;
    logic       clear_overflow;
    logic [7:0] count_out;
    logic       at_limit;
    logic       tc;
    logic       wrap;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    up_counter #(.WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .load          (load),
        .preload_count (preload_count),
        .limit_in      (limit_in),
        .multiply_by_2 (multiply_by_2),
        .enable        (enable),
        .wrap_en       (wrap_en),
        .clear_overflow(clear_overflow),
        .count_out     (count_out),
        .at_limit      (at_limit),
        .tc            (tc),
        .wrap          (wrap),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic flags(input string tag, input logic al, input logic t,
                         input logic w, input logic o);
        chk({tag, "_at_limit"}, {7'd0, at_limit}, {7'd0, al});
        chk({tag, "_tc"}, {7'd0, tc}, {7'd0, t});
        chk({tag, "_wrap"}, {7'd0, wrap}, {7'd0, w});
        chk({tag, "_ovf"}, {7'd0, overflow}, {7'd0, o});
    endtask

    task automatic do_load(input logic [7:0] p, input logic [7:0] l);
        load = 1'b1;
        preload_count = p;
        limit_in = l;
        step();
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        load = 1'b0;
        preload_count = 8'h00;
        limit_in = 8'h00;
        multiply_by_2 = 1'b0;
        enable = 1'b0;
        wrap_en = 1'b0;
        clear_overflow = 1'b0;
        step();
        step();
        chk("rst_count", count_out, 8'h00);
        flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);

        // Free count to FF then hold
        rst = 1'b0;
        enable = 1'b1;
        for (int i = 1; i <= 255; i++) begin
            step();
            chk("run_count", count_out, 8'(i));
            chk("run_tc", {7'd0, tc}, {7'd0, (i == 255)});
        end
        chk("run_at_limit", {7'd0, at_limit}, 8'd1);
        step();
        chk("hold_count", count_out, 8'hFF);
        flags("hold", 1'b1, 1'b0, 1'b0, 1'b0);

        // Wrap sequence 3,4,5,0,1
        wrap_en = 1'b1;
        do_load(8'd3, 8'd5);
        chk("w3", count_out, 8'd3);
        flags("w3", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("w4", count_out, 8'd4);
        step();
        chk("w5", count_out, 8'd5);
        flags("w5", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk("w0", count_out, 8'd0);
        flags("w0", 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk("w1", count_out, 8'd1);
        flags("w1", 1'b0, 1'b0, 1'b0, 1'b0);

        // Preload above limit clamps
        enable = 1'b0;
        do_load(8'd20, 8'd10);
        chk("clamp_count", count_out, 8'd10);
        flags("clamp", 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        flags("clamp2", 1'b1, 1'b0, 1'b0, 1'b1);
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        chk("clr_ovf", {7'd0, overflow}, 8'd0);

        // Doubling
        do_load(8'd4, 8'd9);
        multiply_by_2 = 1'b1;
        step();
        multiply_by_2 = 1'b0;
        chk("dbl8", count_out, 8'd8);
        chk("dbl8_ovf", {7'd0, overflow}, 8'd0);
        do_load(8'd5, 8'd9);
        multiply_by_2 = 1'b1;
        step();
        multiply_by_2 = 1'b0;
        chk("dbl9", count_out, 8'd9);
        flags("dbl9", 1'b1, 1'b1, 1'b0, 1'b1);
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        do_load(8'h80, 8'hFF);
        chk("d80_ovf_pre", {7'd0, overflow}, 8'd0);
        multiply_by_2 = 1'b1;
        step();
        multiply_by_2 = 1'b0;
        chk("dblFF", count_out, 8'hFF);
        flags("dblFF", 1'b1, 1'b1, 1'b0, 1'b1);
        do_load(8'h03, 8'hFF);
        multiply_by_2 = 1'b1;
        step();
        multiply_by_2 = 1'b0;
        chk("dbl6", count_out, 8'h06);

        // Priority: load beats double and enable
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        load = 1'b1;
        multiply_by_2 = 1'b1;
        enable = 1'b1;
        preload_count = 8'd2;
        limit_in = 8'd9;
        step();
        load = 1'b0;
        multiply_by_2 = 1'b0;
        enable = 1'b0;
        chk("prio_count", count_out, 8'd2);
        chk("prio_ovf", {7'd0, overflow}, 8'd0);

        // Set beats clear in the same cycle
        do_load(8'd7, 8'd9);
        multiply_by_2 = 1'b1;
        clear_overflow = 1'b1;
        step();
        multiply_by_2 = 1'b0;
        clear_overflow = 1'b0;
        chk("setwin_count", count_out, 8'd9);
        chk("setwin_ovf", {7'd0, overflow}, 8'd1);

        // Reset mid-count
        wrap_en = 1'b0;
        do_load(8'd0, 8'hFF);
        enable = 1'b1;
        for (int i = 0; i < 7; i++) step();
        chk("pre_rst", count_out, 8'd7);
        chk("pre_rst_ovf", {7'd0, overflow}, 8'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst", count_out, 8'd0);
        flags("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("resume", count_out, 8'd1);

        // Zero limit with wrap
        wrap_en = 1'b1;
        do_load(8'd0, 8'd0);
        chk("z_count", count_out, 8'd0);
        flags("z", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk("z1_count", count_out, 8'd0);
        flags("z1", 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        flags("z2", 1'b1, 1'b0, 1'b1, 1'b0);
        enable = 1'b0;
        step();
        flags("z3", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
